// File: rtl/float_divider.sv
// Iterative binary32 divider (restoring radix-2) with a start/busy/done handshake.
// Optional FDIV_STICKY_ROUND_EN switches rounding from half-up to round-to-nearest-even.
`timescale 1ns/1ps
module float_divider #(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  localparam logic [4:0] STEP  = 5'(ITER_PER_CYCLE);
  localparam logic [4:0] ITERS = 5'd26;

  state_t             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d, sign_q, sign_d;
  logic        [31:0] result_q, result_d;
  logic        [24:0] rem_q, rem_d;
  logic        [25:0] quo_q, quo_d;
  logic        [23:0] mb_q, mb_d;
  logic        [4:0]  cnt_q, cnt_d;
  logic signed [9:0]  diff_q, diff_d;

  logic        [24:0] r_it;
  logic        [25:0] q_it;
  logic               exc_in, a_zero, b_zero, sign_in;

  // Normalise the 26-bit quotient, round, and saturate the exponent range.
  function automatic logic [31:0] norm_pack(input logic sgn, input logic [25:0] q,
                                            input logic [24:0] rem, input logic signed [9:0] diff);
    logic [22:0]       mant;
    logic [23:0]       mant_r;
    logic              rnd, up;
    logic signed [9:0] exp_n, exp_r;
    if (q[25]) begin
      mant = q[24:2]; rnd = q[1]; exp_n = diff;
    end else begin
      mant = q[23:1]; rnd = q[0]; exp_n = diff - 10'sd1;
    end
`ifdef FDIV_STICKY_ROUND_EN
    up = rnd & ((rem != 25'd0) | (q[25] & q[0]) | mant[0]);
`else
    up = rnd;
    if (rem == 25'd0) up = rnd;
`endif
    mant_r = {1'b0, mant} + {23'd0, up};
    exp_r  = exp_n + $signed({9'd0, mant_r[23]});
    if (exp_r >= 10'sd255)    norm_pack = {sgn, 8'hFF, 23'd0};
    else if (exp_r <= 10'sd0) norm_pack = {sgn, 31'd0};
    else                      norm_pack = {sgn, exp_r[7:0], mant_r[22:0]};
  endfunction

  assign exc_in  = (&a[30:23]) | (&b[30:23]);
  assign a_zero  = (a[30:23] == 8'd0);
  assign b_zero  = (b[30:23] == 8'd0);
  assign sign_in = a[31] ^ b[31];

  always_comb begin
    r_it = rem_q;
    q_it = quo_q;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      if (r_it >= {1'b0, mb_q}) begin
        r_it = r_it - {1'b0, mb_q};
        q_it = {q_it[24:0], 1'b1};
      end else begin
        q_it = {q_it[24:0], 1'b0};
      end
      r_it = {r_it[23:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = done_q;
    result_d = result_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    mb_d     = mb_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    diff_d   = diff_q;
    if (irst) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = 32'h0;
      rem_d    = 25'd0;
      quo_d    = 26'd0;
      cnt_d    = 5'd0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          busy_d = 1'b1;
          sign_d = sign_in;
          if (exc_in || b_zero || a_zero) begin
            done_d  = 1'b1;
            state_d = DONE;
            if (exc_in)      result_d = 32'h7F80_0000;
            else if (b_zero) result_d = {sign_in, 8'hFF, 23'd0};
            else             result_d = {sign_in, 31'd0};
          end else begin
            rem_d   = {2'b01, a[22:0]};
            quo_d   = 26'd0;
            cnt_d   = 5'd0;
            mb_d    = {1'b1, b[22:0]};
            diff_d  = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
            state_d = DIV;
          end
        end
        DIV: begin
          rem_d = r_it;
          quo_d = q_it;
          cnt_d = cnt_q + STEP;
          if (cnt_q + STEP == ITERS) state_d = NORM;
        end
        NORM: begin
          result_d = norm_pack(sign_q, quo_q, rem_q, diff_q);
          done_d   = 1'b1;
          state_d  = DONE;
        end
        default: begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
      rem_q    <= 25'd0;
      quo_q    <= 26'd0;
      mb_q     <= 24'd0;
      cnt_q    <= 5'd0;
      sign_q   <= 1'b0;
      diff_q   <= 10'sd0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      mb_q     <= mb_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      diff_q   <= diff_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_float_divider.sv
// Directed-vector bench for float_divider: table of operations plus overlap and abort sequences.
`timescale 1ns/1ps
module tb_float_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_i = 32'h0;
  logic [31:0] b_i = 32'h0;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs[14];

  float_divider dut (
    .clk(clk), .rst_n(rst_n), .irst(irst), .start(start),
    .a(a_i), .b(b_i), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] vq, input int vlat, input string nm);
    int   dk;
    logic busy_ok;
    @(negedge clk);
    start = 1'b1; a_i = va; b_i = vb;
    dk = 0; busy_ok = 1'b1;
    for (int k = 1; k <= 64 && dk == 0; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (done) dk = k;
    end
    chk({nm, " latency"}, dk, vlat);
    chk({nm, " result"}, result, vq);
    chk({nm, " busy span"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    chk({nm, " done pulse"}, {31'd0, done}, 32'd0);
    chk({nm, " busy drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          dk, ndone;
    logic [31:0] res_at_done;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 28, "6/2"};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, "1/3"};
    vecs[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1,  "-1/0"};
    vecs[3]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1,  "inf/1"};
    vecs[4]  = '{32'h80000000, 32'h40A00000, 32'h80000000, 1,  "-0/5"};
    vecs[5]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 28, "overflow"};
    vecs[6]  = '{32'h00800000, 32'h40000000, 32'h00000000, 28, "underflow"};
    vecs[7]  = '{32'h41200000, 32'h40A00000, 32'h40000000, 28, "10/5"};
    vecs[8]  = '{32'h3F800000, 32'h40000000, 32'h3F000000, 28, "1/2"};
    vecs[9]  = '{32'h00000000, 32'h00000000, 32'h7F800000, 1,  "0/0"};
    vecs[10] = '{32'hC0400000, 32'h3FC00000, 32'hC0000000, 28, "-3/1.5"};
    vecs[11] = '{32'h7FC00000, 32'h3F800000, 32'h7F800000, 1,  "nan/1"};
    vecs[12] = '{32'h00400000, 32'h3F800000, 32'h00000000, 1,  "subnorm/1"};
    vecs[13] = '{32'h80800000, 32'h40000000, 32'h80000000, 28, "neg underflow"};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'h0);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].lat, vecs[i].nm);

    // Second start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; a_i = 32'h40C00000; b_i = 32'h40000000;
    dk = 0; ndone = 0; res_at_done = 32'h0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) begin start = 1'b1; a_i = 32'h3F800000; b_i = 32'h40400000; end
      if (k == 6) start = 1'b0;
      if (done) begin
        ndone++;
        if (dk == 0) begin dk = k; res_at_done = result; end
      end
    end
    chk("overlap latency", dk, 28);
    chk("overlap result", res_at_done, 32'h40400000);
    chk("overlap done count", ndone, 1);

    // Abort via irst, then a fresh operation.
    @(negedge clk);
    start = 1'b1; a_i = 32'h40C00000; b_i = 32'h40000000;
    dk = 0; res_at_done = 32'h0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 10) irst = 1'b1;
      if (k == 11) begin
        irst = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort result", result, 32'h0);
      end
      if (k == 12) begin start = 1'b1; a_i = 32'h3F800000; b_i = 32'h40400000; end
      if (k == 13) start = 1'b0;
      if (done && dk == 0) begin dk = k; res_at_done = result; end
    end
    chk("restart latency", dk, 40);
    chk("restart result", res_at_done, 32'h3EAAAAAB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
